// File: rtl/pe_conv_engine_pkg.sv
// pe_conv_engine_pkg: state encoding and sizing/quantisation helpers shared by the convolution PE.
package pe_conv_engine_pkg;

   typedef enum logic [2:0] {IDLE, FETCH, FLUSH, STORE, WRITE, DONE} pe_state_e;

   function automatic int out_dim(int img, int k, int stride);
      return (img - k) / stride + 1;
   endfunction

   function automatic int cw(int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction

   // acc arrives already extended to 64 bits; the caller keeps the low res_w bits
   function automatic logic [63:0] quantise(logic [63:0] acc, logic [4:0] shamt, logic relu,
                                            logic sat, bit sgn, int res_w);
      logic signed [63:0] q, hi, lo;
      q = sgn ? $signed(acc) >>> shamt : $signed(acc >> shamt);
      if (relu && q < 0) q = 64'sd0;
      hi = (64'sd1 <<< (sgn ? res_w - 1 : res_w)) - 64'sd1;
      lo = sgn ? -(64'sd1 <<< (res_w - 1)) : 64'sd0;
      if (sat) q = q > hi ? hi : (q < lo ? lo : q);
      return q;
   endfunction

endpackage

// File: rtl/pe_conv_engine_if.sv
// pe_conv_engine_if: control, buffer-read and output-write signals of the convolution PE.
interface pe_conv_engine_if #(
   parameter int NUM_CH   = 1,
   parameter int IMG_SIZE = 16,
   parameter int K        = 4,
   parameter int DATA_W   = 8,
   parameter int RES_W    = 8,
   parameter int PACK     = 4,
   parameter int ADDR_W   = 8
);
   localparam int IA_W = pe_conv_engine_pkg::cw(IMG_SIZE * IMG_SIZE);
   localparam int FA_W = pe_conv_engine_pkg::cw(K * K);

   logic                     start, relu_en, sat_en;
   logic [4:0]               shamt;
   logic [ADDR_W-1:0]        out_base;
   logic [IA_W-1:0]          img_addr;
   logic [NUM_CH*DATA_W-1:0] img_rdata;
   logic [FA_W-1:0]          flt_addr;
   logic [NUM_CH*DATA_W-1:0] flt_rdata;
   logic                     wr_valid, wr_ready;
   logic [ADDR_W-1:0]        wr_addr;
   logic [PACK*RES_W-1:0]    wr_data;
   logic                     busy, done;

   modport master (
      input  start, relu_en, sat_en, shamt, out_base, img_rdata, flt_rdata, wr_ready,
      output img_addr, flt_addr, wr_valid, wr_addr, wr_data, busy, done
   );

   modport slave (
      output start, relu_en, sat_en, shamt, out_base, img_rdata, flt_rdata, wr_ready,
      input  img_addr, flt_addr, wr_valid, wr_addr, wr_data, busy, done
   );

endinterface

// File: rtl/pe_conv_engine_mac_tree.sv
// pe_conv_engine_mac_tree: combinational per-channel multiply and cross-channel sum for one filter tap.
module pe_conv_engine_mac_tree #(
   parameter int NUM_CH = 1,
   parameter int DATA_W = 8,
   parameter int SIGNED = 0,
   parameter int SUM_W  = 2 * DATA_W + $clog2(NUM_CH)
) (
   input  logic [NUM_CH*DATA_W-1:0] img,
   input  logic [NUM_CH*DATA_W-1:0] flt,
   output logic [SUM_W-1:0]         sum
);

   // operands are widened before multiplying so the low SUM_W product bits are exact either way
   always_comb begin
      sum = '0;
      for (int c = 0; c < NUM_CH; c++)
         sum = sum + (SIGNED != 0
            ? SUM_W'($signed(img[c*DATA_W +: DATA_W])) * SUM_W'($signed(flt[c*DATA_W +: DATA_W]))
            : SUM_W'(img[c*DATA_W +: DATA_W]) * SUM_W'(flt[c*DATA_W +: DATA_W]));
   end

endmodule

// File: rtl/pe_conv_engine.sv
// pe_conv_engine: self-sequenced multi-channel KxK convolution with quantisation and packed word output.
module pe_conv_engine
   import pe_conv_engine_pkg::*;
#(
   parameter int NUM_CH   = 1,
   parameter int IMG_SIZE = 16,
   parameter int K        = 4,
   parameter int STRIDE   = 1,
   parameter int DATA_W   = 8,
   parameter int ACC_W    = 32,
   parameter int RES_W    = 8,
   parameter int PACK     = 4,
   parameter int SIGNED   = 0,
   parameter int ADDR_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   pe_conv_engine_if.master bus
);

   localparam int OD    = out_dim(IMG_SIZE, K, STRIDE);
   localparam int SUM_W = 2 * DATA_W + $clog2(NUM_CH);
   localparam int KW    = cw(K);
   localparam int OW    = cw(OD);
   localparam int LW    = cw(PACK);
   localparam int IA_W  = cw(IMG_SIZE * IMG_SIZE);
   localparam int FA_W  = cw(K * K);

   pe_state_e             state_q, state_d;
   logic [KW-1:0]         kx_q, kx_d, ky_q, ky_d;
   logic [OW-1:0]         ox_q, ox_d, oy_q, oy_d;
   logic [LW-1:0]         lane_q, lane_d;
   logic [ADDR_W-1:0]     word_q, word_d, base_q, base_d;
   logic [ACC_W-1:0]      acc_q, acc_d;
   logic [PACK*RES_W-1:0] pack_q, pack_d;
   logic [4:0]            shamt_q, shamt_d;
   logic                  relu_q, relu_d, sat_q, sat_d, last_q, last_d;
   logic [SUM_W-1:0]      sum;
   logic [ACC_W-1:0]      sum_ext;
   logic [RES_W-1:0]      q_res;
   logic                  kx_end, ky_end, ox_end, oy_end, pix_last, lane_full;

   pe_conv_engine_mac_tree #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .SIGNED(SIGNED)) u_mac (
      .img(bus.img_rdata),
      .flt(bus.flt_rdata),
      .sum(sum)
   );

   assign sum_ext   = SIGNED != 0 ? ACC_W'($signed(sum)) : ACC_W'(sum);
   assign q_res     = RES_W'(quantise(SIGNED != 0 ? 64'($signed(acc_q)) : 64'(acc_q),
                                      shamt_q, relu_q, sat_q, SIGNED != 0, RES_W));
   assign kx_end    = kx_q == KW'(K - 1);
   assign ky_end    = ky_q == KW'(K - 1);
   assign ox_end    = ox_q == OW'(OD - 1);
   assign oy_end    = oy_q == OW'(OD - 1);
   assign pix_last  = ox_end && oy_end;
   assign lane_full = lane_q == LW'(PACK - 1);

   assign bus.img_addr = IA_W'((int'(oy_q) * STRIDE + int'(ky_q)) * IMG_SIZE + int'(ox_q) * STRIDE + int'(kx_q));
   assign bus.flt_addr = FA_W'(int'(ky_q) * K + int'(kx_q));
   assign bus.wr_valid = state_q == WRITE;
   assign bus.wr_addr  = base_q + word_q;
   assign bus.wr_data  = pack_q;
   assign bus.busy     = state_q != IDLE;
   assign bus.done     = state_q == DONE;

   always_comb begin
      state_d = state_q;
      kx_d    = kx_q;
      ky_d    = ky_q;
      ox_d    = ox_q;
      oy_d    = oy_q;
      lane_d  = lane_q;
      word_d  = word_q;
      base_d  = base_q;
      acc_d   = acc_q;
      pack_d  = pack_q;
      shamt_d = shamt_q;
      relu_d  = relu_q;
      sat_d   = sat_q;
      last_d  = last_q;
      case (state_q)
         IDLE: if (bus.start) begin
            state_d = FETCH;
            relu_d  = bus.relu_en;
            sat_d   = bus.sat_en;
            shamt_d = bus.shamt;
            base_d  = bus.out_base;
            kx_d    = '0;
            ky_d    = '0;
            ox_d    = '0;
            oy_d    = '0;
            lane_d  = '0;
            word_d  = '0;
            pack_d  = '0;
            last_d  = 1'b0;
         end
         // read data trails the address by one cycle, so tap 0 clears and later taps add their predecessor
         FETCH: begin
            acc_d   = (kx_q == '0 && ky_q == '0) ? '0 : acc_q + sum_ext;
            kx_d    = kx_end ? '0 : kx_q + KW'(1);
            ky_d    = kx_end ? (ky_end ? '0 : ky_q + KW'(1)) : ky_q;
            state_d = (kx_end && ky_end) ? FLUSH : FETCH;
         end
         FLUSH: begin
            acc_d   = acc_q + sum_ext;
            state_d = STORE;
         end
         STORE: begin
            pack_d[lane_q*RES_W +: RES_W] = q_res;
            last_d  = pix_last;
            ox_d    = pix_last ? ox_q : (ox_end ? '0 : ox_q + OW'(1));
            oy_d    = (pix_last || !ox_end) ? oy_q : oy_q + OW'(1);
            state_d = (lane_full || pix_last) ? WRITE : FETCH;
            lane_d  = (lane_full || pix_last) ? lane_q : lane_q + LW'(1);
         end
         WRITE: if (bus.wr_ready) begin
            pack_d  = '0;
            lane_d  = '0;
            word_d  = word_q + ADDR_W'(1);
            state_d = last_q ? DONE : FETCH;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         kx_q    <= '0;
         ky_q    <= '0;
         ox_q    <= '0;
         oy_q    <= '0;
         lane_q  <= '0;
         word_q  <= '0;
         base_q  <= '0;
         acc_q   <= '0;
         pack_q  <= '0;
         shamt_q <= '0;
         relu_q  <= 1'b0;
         sat_q   <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         kx_q    <= kx_d;
         ky_q    <= ky_d;
         ox_q    <= ox_d;
         oy_q    <= oy_d;
         lane_q  <= lane_d;
         word_q  <= word_d;
         base_q  <= base_d;
         acc_q   <= acc_d;
         pack_q  <= pack_d;
         shamt_q <= shamt_d;
         relu_q  <= relu_d;
         sat_q   <= sat_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: tb/tb_pe_conv_engine.sv
// tb_pe_conv_engine: randomized jobs on a signed 3-channel, stride-2 PE checked against a pixel-level model.
module tb_pe_conv_engine;

   localparam int NUM_CH = 3, IMG = 11, KS = 3, ST = 2, DW = 8, RES_W = 8, PACK = 4, ADDR_W = 8;
   localparam int OD   = (IMG - KS) / ST + 1;
   localparam int NPIX = OD * OD;
   localparam int NW   = (NPIX + PACK - 1) / PACK;
   localparam int IA_W = $clog2(IMG * IMG);

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pe_conv_engine_if #(.NUM_CH(NUM_CH), .IMG_SIZE(IMG), .K(KS), .DATA_W(DW), .RES_W(RES_W),
                       .PACK(PACK), .ADDR_W(ADDR_W)) bus ();

   pe_conv_engine #(.NUM_CH(NUM_CH), .IMG_SIZE(IMG), .K(KS), .STRIDE(ST), .DATA_W(DW), .ACC_W(32),
                    .RES_W(RES_W), .PACK(PACK), .SIGNED(1), .ADDR_W(ADDR_W)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   logic [DW-1:0]         img_m [NUM_CH][1 << IA_W];
   logic [DW-1:0]         flt_m [NUM_CH][KS * KS];
   logic [ADDR_W-1:0]     exp_addr [$];
   logic [PACK*RES_W-1:0] exp_data [$];
   int                    n_chk = 0, n_fail = 0, done_cnt = 0, words = 0;
   bit                    stall = 1'b0, held = 1'b0;
   logic [ADDR_W-1:0]     h_addr;
   logic [PACK*RES_W-1:0] h_data;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // one-cycle-latency image and filter buffers
   always @(posedge clk)
      for (int c = 0; c < NUM_CH; c++) begin
         bus.img_rdata[c*DW +: DW] <= img_m[c][bus.img_addr];
         bus.flt_rdata[c*DW +: DW] <= flt_m[c][bus.flt_addr];
      end

   initial begin
      bus.wr_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1 bus.wr_ready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
      end
   end

   always @(negedge clk) begin
      if (bus.done) done_cnt++;
      if (bus.wr_valid) begin
         if (held) begin
            check("hold_addr", bus.wr_addr, h_addr);
            check("hold_data", bus.wr_data, h_data);
         end
         if (bus.wr_ready) begin
            check("word_expected", exp_addr.size() != 0, 1);
            if (exp_addr.size() != 0) begin
               check("wr_addr", bus.wr_addr, exp_addr.pop_front());
               check("wr_data", bus.wr_data, exp_data.pop_front());
            end
            words++;
            held = 1'b0;
         end else begin
            held   = 1'b1;
            h_addr = bus.wr_addr;
            h_data = bus.wr_data;
         end
      end else held = 1'b0;
   end

   task automatic fill_mem(input int mode);
      for (int c = 0; c < NUM_CH; c++) begin
         for (int a = 0; a < (1 << IA_W); a++) img_m[c][a] = mode != 0 ? 8'd5 : 8'($urandom);
         for (int t = 0; t < KS * KS; t++) flt_m[c][t] = mode != 0 ? 8'hFF : 8'($urandom);
      end
   endtask

   task automatic build_model(input logic [4:0] sh, input bit relu, input bit sat, input logic [ADDR_W-1:0] base);
      logic [PACK*RES_W-1:0] w [NW];
      int acc, q;
      for (int i = 0; i < NW; i++) w[i] = '0;
      for (int p = 0; p < NPIX; p++) begin
         acc = 0;
         for (int c = 0; c < NUM_CH; c++)
            for (int ky = 0; ky < KS; ky++)
               for (int kx = 0; kx < KS; kx++)
                  acc += int'($signed(img_m[c][((p / OD) * ST + ky) * IMG + (p % OD) * ST + kx]))
                       * int'($signed(flt_m[c][ky * KS + kx]));
         q = acc >>> sh;
         if (relu && q < 0) q = 0;
         if (sat) q = q > 127 ? 127 : (q < -128 ? -128 : q);
         w[p / PACK][(p % PACK) * RES_W +: RES_W] = q[7:0];
      end
      exp_addr.delete();
      exp_data.delete();
      for (int i = 0; i < NW; i++) begin
         exp_addr.push_back(base + ADDR_W'(i));
         exp_data.push_back(w[i]);
      end
   endtask

   task automatic run_job(input int mode, input logic [4:0] sh, input bit relu, input bit sat,
                          input logic [ADDR_W-1:0] base, input bit extra_start, input bit abort);
      fill_mem(mode);
      build_model(sh, relu, sat, base);
      done_cnt = 0;
      words    = 0;
      @(negedge clk);
      bus.start    = 1'b1;
      bus.shamt    = sh;
      bus.relu_en  = relu;
      bus.sat_en   = sat;
      bus.out_base = base;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.shamt    = 5'($urandom);
      bus.relu_en  = ~relu;
      bus.sat_en   = ~sat;
      bus.out_base = 8'($urandom);
      check("busy_after_start", bus.busy, 1);
      if (abort) begin
         repeat (115) @(negedge clk);
         check("busy_before_abort", bus.busy, 1);
         rst = 1'b0;
         @(negedge clk);
         rst = 1'b1;
         check("abort_busy", bus.busy, 0);
         check("abort_valid", bus.wr_valid, 0);
         repeat (20) @(negedge clk);
         check("abort_no_done", done_cnt, 0);
         check("abort_idle", bus.busy, 0);
         exp_addr.delete();
         exp_data.delete();
         return;
      end
      for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
         @(negedge clk);
         bus.start = extra_start && (i == 40);
      end
      bus.start = 1'b0;
      check("done_seen", done_cnt, 1);
      check("word_count", words, NW);
      check("queue_drained", exp_addr.size(), 0);
      @(negedge clk);
      check("busy_clear", bus.busy, 0);
      repeat (5) @(negedge clk);
      check("done_once", done_cnt, 1);
      check("no_restart", bus.busy, 0);
   endtask

   initial begin
      bus.start    = 1'b0;
      bus.relu_en  = 1'b0;
      bus.sat_en   = 1'b0;
      bus.shamt    = '0;
      bus.out_base = '0;
      fill_mem(0);
      repeat (3) @(negedge clk);
      check("rst_busy", bus.busy, 0);
      check("rst_valid", bus.wr_valid, 0);
      check("rst_done", bus.done, 0);
      check("rst_img_addr", bus.img_addr, 0);
      check("rst_flt_addr", bus.flt_addr, 0);
      check("rst_wr_data", bus.wr_data, 0);
      check("rst_wr_addr", bus.wr_addr, 0);
      rst = 1'b1;
      stall = 1'b1;
      run_job(0, 5'($urandom_range(0, 12)), 1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
      run_job(0, 5'($urandom_range(0, 12)), 1'b1, 1'b1, 8'hFC, 1'b0, 1'b0);
      run_job(0, 5'($urandom_range(0, 12)), 1'b0, 1'b0, 8'h40, 1'b0, 1'b0);
      run_job(1, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      run_job(1, 5'd0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0);
      run_job(0, 5'($urandom_range(0, 12)), 1'($urandom), 1'($urandom), 8'($urandom), 1'b1, 1'b0);
      stall = 1'b0;
      run_job(0, 5'd3, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1);
      stall = 1'b1;
      run_job(0, 5'($urandom_range(0, 12)), 1'b0, 1'b1, 8'h20, 1'b0, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
